fm_i2c_sequencer: RTL and testbench

// - Upstream command source for the write-only I2C controller: generates its 4x-bit-rate clock enable,

---
 rtl/fm_i2c_sequencer_if.sv | 11 +
 rtl/fm_i2c_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_fm_i2c_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fm_i2c_sequencer_if.sv
// Request/ack bus between the FM tuner init sequencer (master) and the write-only I2C controller (slave).
interface fm_i2c_sequencer_if;
   logic            en;
   logic [6:0]      addr;
   logic [1:0][7:0] wdata;
   logic            req;
   logic            ack;

   modport master (output en, output addr, output wdata, output req, input ack);
   modport slave  (input en, input addr, input wdata, input req, output ack);
endinterface

// File: rtl/fm_i2c_sequencer.sv
// FM tuner I2C command sequencer: bit-rate enable generator plus init-table walker issuing 2-byte writes.
// Optional retune path (chan/tune ports, pending retune word) enabled by defining FM_I2C_RETUNE_EN.
module fm_i2c_sequencer #(
   parameter int unsigned             DIV         = 125,
   parameter logic [6:0]              DEV_ADDR    = 7'h10,
   parameter int unsigned             NUM_WORDS   = 4,
   parameter logic [NUM_WORDS*16-1:0] INIT_TABLE  = {16'h8881, 16'h0010, 16'hC00D, 16'hC003},
   parameter int unsigned             PWRUP_TICKS = 400,
   parameter int unsigned             GAP_TICKS   = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   output logic                busy,
   output logic                done,
   fm_i2c_sequencer_if.master  bus
`ifdef FM_I2C_RETUNE_EN
   ,
   input  logic [9:0]          chan,
   input  logic                tune
`endif
);

   localparam int unsigned      IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_WORDS - 1);
   localparam logic [15:0]      LAST_DIV  = 16'(DIV - 1);
   localparam logic [16:0]      PWRUP_LIM = 17'(PWRUP_TICKS);
   localparam logic [16:0]      GAP_LIM   = 17'(GAP_TICKS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_LOAD,
      S_REQ,
      S_GAP
   } state_t;

   state_t           state, state_nx;
   logic [15:0]      pcnt;
   logic             en_i;
   logic [15:0]      tick, tick_nx;
   logic [IDX_W-1:0] idx, idx_nx;
   logic             req_r, req_nx;
   logic [15:0]      word, word_nx;
   logic             done_r, done_nx;
   logic             last_xfer;
   logic [16:0]      tick_inc;

`ifdef FM_I2C_RETUNE_EN
   logic             tx, tx_nx;
   logic             pend_valid, pend_valid_nx;
   logic [15:0]      pend_word, pend_word_nx;

   assign last_xfer = tx || (idx == LAST_IDX);
`else
   assign last_xfer = (idx == LAST_IDX);
`endif

   assign en_i      = (pcnt == LAST_DIV);
   assign tick_inc  = {1'b0, tick} + 17'd1;

   assign bus.en    = en_i;
   assign bus.addr  = DEV_ADDR;
   assign bus.wdata = word;
   assign bus.req   = req_r;
   assign done      = done_r;
   assign busy      = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         pcnt       <= '0;
         state      <= S_IDLE;
         tick       <= '0;
         idx        <= '0;
         req_r      <= 1'b0;
         word       <= '0;
         done_r     <= 1'b0;
`ifdef FM_I2C_RETUNE_EN
         tx         <= 1'b0;
         pend_valid <= 1'b0;
         pend_word  <= '0;
`endif
      end else begin
         pcnt       <= en_i ? '0 : pcnt + 16'd1;
         state      <= state_nx;
         tick       <= tick_nx;
         idx        <= idx_nx;
         req_r      <= req_nx;
         word       <= word_nx;
         done_r     <= done_nx;
`ifdef FM_I2C_RETUNE_EN
         tx         <= tx_nx;
         pend_valid <= pend_valid_nx;
         pend_word  <= pend_word_nx;
`endif
      end
   end

   always_comb begin
      state_nx = state;
      tick_nx  = tick;
      idx_nx   = idx;
      req_nx   = req_r;
      word_nx  = word;
      done_nx  = 1'b0;
`ifdef FM_I2C_RETUNE_EN
      tx_nx         = tx;
      pend_valid_nx = pend_valid;
      pend_word_nx  = pend_word;
      // A new tune always wins over consumption of the previous pending word.
      if (tune) begin
         pend_valid_nx = 1'b1;
         pend_word_nx  = {chan, 6'b010000};
      end else if (state == S_LOAD && en_i && tx) begin
         pend_valid_nx = 1'b0;
      end
`endif
      unique case (state)
         S_IDLE: begin
            if (start) begin
               state_nx = S_WAIT;
               tick_nx  = '0;
            end
`ifdef FM_I2C_RETUNE_EN
            else if (tune) begin
               state_nx = S_LOAD;
               tx_nx    = 1'b1;
            end else if (pend_valid) begin
               state_nx = S_GAP;
               tick_nx  = '0;
               tx_nx    = 1'b1;
            end
`endif
         end
         S_WAIT: begin
            if (en_i) begin
               if (tick_inc >= PWRUP_LIM) begin
                  state_nx = S_LOAD;
                  tick_nx  = '0;
               end else begin
                  tick_nx  = tick_inc[15:0];
               end
            end
         end
         S_LOAD: begin
            if (en_i) begin
               word_nx  = INIT_TABLE[int'(idx)*16 +: 16];
`ifdef FM_I2C_RETUNE_EN
               if (tx) word_nx = pend_word;
`endif
               req_nx   = 1'b1;
               state_nx = S_REQ;
            end
         end
         S_REQ: begin
            if (en_i && bus.ack) begin
               req_nx = 1'b0;
               if (last_xfer) begin
                  done_nx  = 1'b1;
                  idx_nx   = '0;
                  state_nx = S_IDLE;
`ifdef FM_I2C_RETUNE_EN
                  tx_nx    = 1'b0;
`endif
               end else begin
                  idx_nx   = idx + IDX_W'(1);
                  tick_nx  = '0;
                  state_nx = S_GAP;
               end
            end
         end
         S_GAP: begin
            if (en_i) begin
               if (tick_inc >= GAP_LIM) begin
                  state_nx = S_LOAD;
                  tick_nx  = '0;
               end else begin
                  tick_nx  = tick_inc[15:0];
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_fm_i2c_sequencer.sv
// Self-checking bench for fm_i2c_sequencer: en-tick schedule model compared every cycle plus directed literals.
module tb_fm_i2c_sequencer;

   localparam int          DIV  = 4;
   localparam logic [6:0]  DEV  = 7'h10;
   localparam int          NW   = 2;
   localparam logic [15:0] W0   = 16'h0010;
   localparam logic [15:0] W1   = 16'hC001;
   localparam logic [31:0] TBL  = {W1, W0};
   localparam int          PWR  = 2;
   localparam int          GAP  = 3;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic busy, done;
`ifdef FM_I2C_RETUNE_EN
   logic [9:0] chan = '0;
   logic       tune = 1'b0;
`endif

   fm_i2c_sequencer_if bus();

   fm_i2c_sequencer #(
      .DIV(DIV), .DEV_ADDR(DEV), .NUM_WORDS(NW), .INIT_TABLE(TBL),
      .PWRUP_TICKS(PWR), .GAP_TICKS(GAP)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .bus(bus.master)
`ifdef FM_I2C_RETUNE_EN
      , .chan(chan), .tune(tune)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] tbl_word(input int i);
      return (i == 0) ? W0 : W1;
   endfunction

   // Schedule model: outputs derived from en-tick numbers at which requests are due.
   bit          m_valid = 0;
   int          m_c, m_e, m_target, m_idx;
   bit          m_busy, m_req, m_done, m_tx, m_pend;
   logic [15:0] m_wdata, m_pword;
   int          done_cnt = 0;
   logic [15:0] last_word = '0;
   logic        req_seen_q = 1'b0;

   initial begin
      forever begin
         @(negedge clk);
         if (m_valid) begin
            chk("en",    bus.en,    ((m_c % DIV) == DIV - 1));
            chk("req",   bus.req,   m_req);
            chk("busy",  busy,      m_busy);
            chk("done",  done,      m_done);
            chk("wdata", bus.wdata, m_wdata);
            chk("addr",  bus.addr,  DEV);
         end
         if (bus.req && !req_seen_q) last_word = bus.wdata;
         req_seen_q = bus.req;
         if (done) done_cnt++;
         if (reset) begin
            m_valid = 1; m_c = 0; m_e = 0; m_target = -1; m_idx = 0;
            m_busy = 0; m_req = 0; m_done = 0; m_tx = 0; m_pend = 0;
            m_wdata = '0; m_pword = '0;
         end else if (m_valid) begin
            bit en_now, was_busy;
            en_now   = ((m_c % DIV) == DIV - 1);
            was_busy = m_busy;
            m_c++;
            m_done = 0;
            if (en_now) begin
               m_e++;
               if (m_busy && !m_req && m_e == m_target) begin
                  m_req = 1;
                  if (m_tx) begin
                     m_wdata = m_pword;
                     m_pend  = 0;
                  end else begin
                     m_wdata = tbl_word(m_idx);
                  end
               end else if (m_req && bus.ack) begin
                  m_req = 0;
                  if (m_tx) begin
                     m_done = 1; m_busy = 0; m_tx = 0;
                  end else if (m_idx == NW - 1) begin
                     m_done = 1; m_busy = 0; m_idx = 0;
                  end else begin
                     m_idx++;
                     m_target = m_e + GAP + 1;
                  end
               end
            end
            if (!was_busy) begin
               if (start) begin
                  m_busy = 1; m_target = m_e + PWR + 1;
               end
`ifdef FM_I2C_RETUNE_EN
               else if (tune) begin
                  m_busy = 1; m_tx = 1; m_target = m_e + 1;
               end else if (m_pend) begin
                  m_busy = 1; m_tx = 1; m_target = m_e + GAP + 1;
               end
`endif
            end
`ifdef FM_I2C_RETUNE_EN
            if (tune) begin
               m_pend  = 1;
               m_pword = {chan, 6'b010000};
            end
`endif
         end
      end
   end

   // Controller stand-in: mode 0 never acks, 1 acks on the 3rd en tick of a request, 2 holds ack off-en.
   int mode = 0;
   int txn  = 0;
   initial begin
      int   ticks;
      logic req_q;
      ticks   = 0;
      req_q   = 1'b0;
      bus.ack = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!bus.req) begin
            ticks   = 0;
            bus.ack = 1'b0;
         end else begin
            case (mode)
               1: begin
                  bus.ack = bus.en && (ticks >= 2);
                  if (bus.en) ticks++;
               end
               2:       bus.ack = !bus.en;
               default: bus.ack = 1'b0;
            endcase
         end
         if (bus.req && !req_q) txn++;
         req_q = bus.req;
      end
   end

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

`ifdef FM_I2C_RETUNE_EN
   task automatic pulse_tune(input logic [9:0] c);
      @(posedge clk); #1 chan = c; tune = 1'b1;
      @(posedge clk); #1 tune = 1'b0;
   endtask
`endif

   task automatic wait_req(input string name);
      bit seen;
      seen = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (bus.req) begin
            seen = 1;
            break;
         end
      end
      chk(name, seen, 1);
   endtask

   task automatic wait_done(input string name);
      bit seen;
      seen = 0;
      for (int i = 0; i < 800; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
            break;
         end
      end
      chk(name, seen, 1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_en, n_en, t0, d0;
      bit seen;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state and prescaler phase
      first_en = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (i == 1) begin
            chk("rst_busy",  busy,      0);
            chk("rst_req",   bus.req,   0);
            chk("rst_done",  done,      0);
            chk("rst_wdata", bus.wdata, 0);
            chk("rst_en",    bus.en,    0);
         end
         if (bus.en) begin
            first_en = i;
            break;
         end
      end
      chk("first_en_clk", first_en, 4);
      repeat (12) @(negedge clk);
      chk("idle_busy", busy, 0);

      // Init sequence, with a start pulse while busy
      mode = 1; t0 = txn; d0 = done_cnt;
      pulse_start();
      n_en = 0; seen = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.req) begin
            seen = 1;
            break;
         end
         if (bus.en) n_en++;
      end
      chk("req_seen", seen, 1);
      chk("ticks_to_req", n_en, PWR + 1);
      chk("word0_hi", bus.wdata[1], 8'h00);
      chk("word0_lo", bus.wdata[0], 8'h10);
      pulse_start();
      wait_done("seq_done");
      repeat (20) @(negedge clk);
      chk("seq_word1", last_word, 16'hC001);
      chk("seq_txns", txn - t0, 2);
      chk("seq_dones", done_cnt - d0, 1);

      // ack held high only on non-en cycles is ignored
      mode = 2;
      pulse_start();
      wait_req("hold_req_up");
      repeat (20) @(negedge clk);
      chk("hold_req", bus.req, 1);
      chk("hold_word", bus.wdata, 16'h0010);
      mode = 1;
      seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.en && bus.ack) begin
            seen = 1;
            break;
         end
      end
      chk("ack_on_en", seen, 1);
      @(negedge clk);
      chk("req_drop", bus.req, 0);
      wait_done("hold_done");
      repeat (8) @(negedge clk);

      // Reset while a request is outstanding
      mode = 0;
      pulse_start();
      wait_req("rst_req_up");
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("midrst_req", bus.req, 0);
      chk("midrst_busy", busy, 0);
      mode = 1; t0 = txn;
      pulse_start();
      wait_done("restart_done");
      repeat (8) @(negedge clk);
      chk("restart_txns", txn - t0, 2);
      chk("restart_word1", last_word, 16'hC001);

`ifdef FM_I2C_RETUNE_EN
      // Retune from idle, then retune requests while the init sequence runs
      t0 = txn; d0 = done_cnt;
      pulse_tune(10'd93);
      wait_done("tune_done");
      repeat (4) @(negedge clk);
      chk("tune_word", last_word, 16'h1750);
      chk("tune_txns", txn - t0, 1);
      chk("tune_dones", done_cnt - d0, 1);
      t0 = txn;
      pulse_start();
      wait_req("busy_tune_req");
      pulse_tune(10'd5);
      repeat (2) @(negedge clk);
      pulse_tune(10'd7);
      wait_done("busy_init_done");
      wait_done("busy_tune_done");
      repeat (4) @(negedge clk);
      chk("busy_tune_word", last_word, 16'h01D0);
      chk("busy_tune_txns", txn - t0, 3);
`endif

      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
